// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Command-driven controller for the 16-bit A/B/C register + ALU datapath.
// One command is accepted at a time over cmd_valid/cmd_ready. Each command
// is expanded into the phases LOAD (register-write strobes), EXEC (register
// read strobes plus outregwrite), READ (one output-register read strobe) and
// DONE (one-cycle done pulse). Phases that the command does not need are
// skipped. All outputs are registered Moore outputs.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_x, cmd_y          opcode and operands, captured on accept
//   cmd_load[2:0]                 A/B/C register write enables
//   cmd_rsel[1:0]                 A/C register read enables
//   cmd_dst[1:0]                  outregwrite code, 00 = no execute phase
//   op_code_alu, Mem_Dat_X/Y      captured opcode/operands to the datapath
//   aregwrite, bregwrite, cregwrite
//   aregread, cregread, outregwrite
//   aoutregread, boutregread, coutregread
//   done                          one-cycle completion pulse
//
// Optional feature macro: DATAPATH_SEQUENCER_PERF_EN
//   Adds output perf_cnt[15:0], a wrapping count of done pulses.
// -----------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int DATA_W      = 16,
  parameter int OP_W        = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_y,
  input  logic [2:0]        cmd_load,
  input  logic [1:0]        cmd_rsel,
  input  logic [1:0]        cmd_dst,
  output logic [OP_W-1:0]   op_code_alu,
  output logic [DATA_W-1:0] Mem_Dat_X,
  output logic [DATA_W-1:0] Mem_Dat_Y,
  output logic              aregwrite,
  output logic              bregwrite,
  output logic              cregwrite,
  output logic              aregread,
  output logic              cregread,
  output logic [1:0]        outregwrite,
  output logic              aoutregread,
  output logic              boutregread,
  output logic              coutregread,
  output logic              done
`ifdef DATAPATH_SEQUENCER_PERF_EN
  ,
  output logic [15:0]       perf_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  // The phase counter is loaded with (cycles - 1) and the phase ends at 0.
  localparam logic [3:0] LOAD_CNT = 4'(LOAD_CYCLES - 1);
  localparam logic [3:0] EXEC_CNT = 4'(EXEC_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [2:0]          load_q, load_d;
  logic [1:0]          rsel_q, rsel_d;
  logic [1:0]          dst_q, dst_d;
  logic                ready_q, ready_d;
  logic                aw_q, aw_d, bw_q, bw_d, cw_q, cw_d;
  logic                ar_q, ar_d, cr_q, cr_d;
  logic [1:0]          ow_q, ow_d;
  logic                aor_q, aor_d, bor_q, bor_d, cor_q, cor_d;
  logic                done_q, done_d;
  logic [15:0]         perf_q, perf_d;

  // Next-state, command capture and phase counter, followed by Moore output
  // decode from the next state so the registered outputs line up with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    load_d  = load_q;
    rsel_d  = rsel_q;
    dst_d   = dst_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          x_d    = cmd_x;
          y_d    = cmd_y;
          load_d = cmd_load;
          rsel_d = cmd_rsel;
          dst_d  = cmd_dst;
          if (cmd_load != 3'd0) begin
            state_d = LOAD;
            cnt_d   = LOAD_CNT;
          end else if (cmd_dst != 2'd0) begin
            state_d = EXEC;
            cnt_d   = EXEC_CNT;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (cnt_q == 4'd0) begin
          if (dst_q != 2'd0) begin
            state_d = EXEC;
            cnt_d   = EXEC_CNT;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = READ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ready_d = (state_d == IDLE);
    aw_d    = (state_d == LOAD) && load_d[0];
    bw_d    = (state_d == LOAD) && load_d[1];
    cw_d    = (state_d == LOAD) && load_d[2];
    ar_d    = (state_d == EXEC) && rsel_d[0];
    cr_d    = (state_d == EXEC) && rsel_d[1];
    ow_d    = (state_d == EXEC) ? dst_d : 2'b00;
    aor_d   = (state_d == READ) && (dst_d == 2'b01);
    bor_d   = (state_d == READ) && (dst_d == 2'b10);
    cor_d   = (state_d == READ) && (dst_d == 2'b11);
    done_d  = (state_d == DONE);
    // Counts alongside done so the count is visible in the done cycle.
    perf_d  = done_d ? (perf_q + 16'd1) : perf_q;
  end

  // State, captured command and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      load_q  <= 3'd0;
      rsel_q  <= 2'd0;
      dst_q   <= 2'd0;
      ready_q <= 1'b1;
      aw_q    <= 1'b0;
      bw_q    <= 1'b0;
      cw_q    <= 1'b0;
      ar_q    <= 1'b0;
      cr_q    <= 1'b0;
      ow_q    <= 2'b00;
      aor_q   <= 1'b0;
      bor_q   <= 1'b0;
      cor_q   <= 1'b0;
      done_q  <= 1'b0;
      perf_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      load_q  <= load_d;
      rsel_q  <= rsel_d;
      dst_q   <= dst_d;
      ready_q <= ready_d;
      aw_q    <= aw_d;
      bw_q    <= bw_d;
      cw_q    <= cw_d;
      ar_q    <= ar_d;
      cr_q    <= cr_d;
      ow_q    <= ow_d;
      aor_q   <= aor_d;
      bor_q   <= bor_d;
      cor_q   <= cor_d;
      done_q  <= done_d;
      perf_q  <= perf_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign op_code_alu = op_q;
  assign Mem_Dat_X   = x_q;
  assign Mem_Dat_Y   = y_q;
  assign aregwrite   = aw_q;
  assign bregwrite   = bw_q;
  assign cregwrite   = cw_q;
  assign aregread    = ar_q;
  assign cregread    = cr_q;
  assign outregwrite = ow_q;
  assign aoutregread = aor_q;
  assign boutregread = bor_q;
  assign coutregread = cor_q;
  assign done        = done_q;

`ifdef DATAPATH_SEQUENCER_PERF_EN
  assign perf_cnt = perf_q;
`else
  logic perf_unused_s;
  assign perf_unused_s = ^perf_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Directed stimulus with hand-computed expectations. The driver pushes one
// expected-response record per command into a scoreboard queue; a monitor
// sampling on the falling edge records, per strobe, a bitmask of the cycles
// (counted from the accept edge, cycle 1 = first cycle after accept) in
// which it was high, and pops/compares the record when done is seen.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_x, cmd_y;
  logic [2:0]  cmd_load;
  logic [1:0]  cmd_rsel, cmd_dst;
  logic [3:0]  op_code_alu;
  logic [15:0] Mem_Dat_X, Mem_Dat_Y;
  logic        aregwrite, bregwrite, cregwrite, aregread, cregread;
  logic [1:0]  outregwrite;
  logic        aoutregread, boutregread, coutregread, done;
`ifdef DATAPATH_SEQUENCER_PERF_EN
  logic [15:0] perf_cnt;
`endif

  datapath_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_load(cmd_load), .cmd_rsel(cmd_rsel), .cmd_dst(cmd_dst),
    .op_code_alu(op_code_alu), .Mem_Dat_X(Mem_Dat_X), .Mem_Dat_Y(Mem_Dat_Y),
    .aregwrite(aregwrite), .bregwrite(bregwrite), .cregwrite(cregwrite),
    .aregread(aregread), .cregread(cregread), .outregwrite(outregwrite),
    .aoutregread(aoutregread), .boutregread(boutregread), .coutregread(coutregread),
    .done(done)
`ifdef DATAPATH_SEQUENCER_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] aw, bw, cw, ar, cr, ow, aor, bor, cor;
    logic [1:0]  dst;
    logic [3:0]  op;
    logic [15:0] x, y;
    bit          chk_gap;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ndone = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int lat,
                          input logic [31:0] aw, input logic [31:0] bw, input logic [31:0] cw,
                          input logic [31:0] ar, input logic [31:0] cr, input logic [31:0] ow,
                          input logic [31:0] aor, input logic [31:0] bor, input logic [31:0] cor,
                          input logic [1:0] dst, input logic [3:0] op,
                          input logic [15:0] x, input logic [15:0] y, input bit gap);
    exp_t e;
    e.lat = lat; e.aw = aw; e.bw = bw; e.cw = cw; e.ar = ar; e.cr = cr; e.ow = ow;
    e.aor = aor; e.bor = bor; e.cor = cor; e.dst = dst; e.op = op; e.x = x; e.y = y;
    e.chk_gap = gap;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit          busy, post;
    int          cyc, ncyc, done_t, rdy_bad, ow_bad;
    logic [31:0] m_aw, m_bw, m_cw, m_ar, m_cr, m_ow, m_aor, m_bor, m_cor;
    logic [3:0]  l_op;
    logic [15:0] l_x, l_y;
    exp_t        e;
    busy = 0; post = 0; cyc = 0; ncyc = 0; done_t = 0; rdy_bad = 0; ow_bad = 0;
    m_aw = 0; m_bw = 0; m_cw = 0; m_ar = 0; m_cr = 0; m_ow = 0; m_aor = 0; m_bor = 0; m_cor = 0;
    l_op = 0; l_x = 0; l_y = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        busy = 0;
        post = 0;
        chk("no_done_in_reset", {31'd0, done}, 32'd0);
      end else begin
        if (post) begin
          chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
          chk("op_held", {28'd0, op_code_alu}, {28'd0, l_op});
          chk("x_held", {16'd0, Mem_Dat_X}, {16'd0, l_x});
          chk("y_held", {16'd0, Mem_Dat_Y}, {16'd0, l_y});
          post = 0;
        end
        if (busy) begin
          cyc++;
          if (cyc < 32) begin
            m_aw[cyc] = aregwrite;   m_bw[cyc] = bregwrite;   m_cw[cyc] = cregwrite;
            m_ar[cyc] = aregread;    m_cr[cyc] = cregread;    m_ow[cyc] = (outregwrite != 2'b00);
            m_aor[cyc] = aoutregread; m_bor[cyc] = boutregread; m_cor[cyc] = coutregread;
          end
          if (cmd_ready) rdy_bad++;
          if (sb.size() > 0 && outregwrite != 2'b00 && outregwrite != sb[0].dst) ow_bad++;
          if (done) begin
            if (sb.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_done: done=1 expected no command pending at %0t", $time);
            end else begin
              e = sb.pop_front();
              chk("latency", cyc, e.lat);
              chk("aregwrite_mask", m_aw, e.aw);
              chk("bregwrite_mask", m_bw, e.bw);
              chk("cregwrite_mask", m_cw, e.cw);
              chk("aregread_mask", m_ar, e.ar);
              chk("cregread_mask", m_cr, e.cr);
              chk("outregwrite_mask", m_ow, e.ow);
              chk("outregwrite_value_errs", ow_bad, 0);
              chk("aoutregread_mask", m_aor, e.aor);
              chk("boutregread_mask", m_bor, e.bor);
              chk("coutregread_mask", m_cor, e.cor);
              chk("ready_low_while_busy", rdy_bad, 0);
              chk("op_code_alu", {28'd0, op_code_alu}, {28'd0, e.op});
              chk("Mem_Dat_X", {16'd0, Mem_Dat_X}, {16'd0, e.x});
              chk("Mem_Dat_Y", {16'd0, Mem_Dat_Y}, {16'd0, e.y});
              l_op = e.op; l_x = e.x; l_y = e.y;
              ndone++;
            end
            busy = 0;
            post = 1;
            done_t = ncyc;
          end
        end else if (done) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done=1 while idle at %0t", $time);
        end
        if (!busy && cmd_ready && cmd_valid) begin
          if (sb.size() > 0 && sb[0].chk_gap) chk("b2b_gap", ncyc - done_t, 1);
          busy = 1; cyc = 0; rdy_bad = 0; ow_bad = 0;
          m_aw = 0; m_bw = 0; m_cw = 0; m_ar = 0; m_cr = 0; m_ow = 0;
          m_aor = 0; m_bor = 0; m_cor = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic [2:0] ld, input logic [1:0] rs, input logic [1:0] ds,
                      input bit hold);
    bit ok;
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_load = ld; cmd_rsel = rs; cmd_dst = ds;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: %0d commands pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_strobes"}, {22'd0, aregwrite, bregwrite, cregwrite, aregread, cregread,
        outregwrite, aoutregread, boutregread, coutregread}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_operands"}, {op_code_alu, Mem_Dat_X, Mem_Dat_Y} == 36'd0 ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_x = 16'd0; cmd_y = 16'd0;
    cmd_load = 3'd0; cmd_rsel = 2'd0; cmd_dst = 2'd0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: load A and C, read A/C, dst 01
    push_exp(6, 32'h6, 32'h0, 32'h6, 32'h18, 32'h18, 32'h18, 32'h20, 32'h0, 32'h0,
             2'b01, 4'b0000, 16'h0005, 16'h0001, 0);
    send(4'b0000, 16'h0005, 16'h0001, 3'b101, 2'b11, 2'b01, 0);
    wait_idle();

    // 2: B-only load, dst 10, no reads
    push_exp(6, 32'h0, 32'h6, 32'h0, 32'h0, 32'h0, 32'h18, 32'h0, 32'h20, 32'h0,
             2'b10, 4'b0011, 16'h0005, 16'h0000, 0);
    send(4'b0011, 16'h0005, 16'h0000, 3'b010, 2'b00, 2'b10, 0);
    wait_idle();

    // 3: null command
    push_exp(1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             2'b00, 4'b1111, 16'hBEEF, 16'hCAFE, 0);
    send(4'b1111, 16'hBEEF, 16'hCAFE, 3'b000, 2'b11, 2'b00, 0);
    wait_idle();

    // 4: back-to-back with cmd_valid held high
    push_exp(6, 32'h6, 32'h0, 32'h0, 32'h18, 32'h0, 32'h18, 32'h0, 32'h0, 32'h20,
             2'b11, 4'b0101, 16'h1234, 16'hABCD, 0);
    push_exp(4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h6, 32'h8, 32'h0, 32'h0,
             2'b01, 4'b0110, 16'h00FF, 16'hFF00, 1);
    send(4'b0101, 16'h1234, 16'hABCD, 3'b001, 2'b01, 2'b11, 1);
    send(4'b0110, 16'h00FF, 16'hFF00, 3'b000, 2'b10, 2'b01, 0);
    wait_idle();

    // 5: reset during EXEC aborts without done
    send(4'b1010, 16'h0A0A, 16'h5050, 3'b100, 2'b00, 2'b11, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("exec_before_reset", {30'd0, outregwrite}, 32'd3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;

    // 6: fresh command after reset
    push_exp(6, 32'h6, 32'h6, 32'h0, 32'h0, 32'h0, 32'h18, 32'h20, 32'h0, 32'h0,
             2'b01, 4'b0001, 16'h0007, 16'h0009, 0);
    send(4'b0001, 16'h0007, 16'h0009, 3'b011, 2'b00, 2'b01, 0);
    wait_idle();

`ifdef DATAPATH_SEQUENCER_PERF_EN
    // Counter was cleared by the mid-command reset; only command 6 completed since.
    chk("perf_cnt", {16'd0, perf_cnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
